// File: rtl/cpu5_memarb_if.sv
// rtl/cpu5_memarb_if.sv - fetch, load/store, memory and status signals of the cpu5 memory arbiter
interface cpu5_memarb_if #(
  parameter int XLEN = 32
);
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_done;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_rdata;
  logic            d_done;
  logic            mem_valid;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            stall;
  logic            err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rvalid, mem_rdata,
    output if_rdata, if_done, d_rdata, d_done, mem_valid, mem_we, mem_addr, mem_wdata, stall, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rvalid, mem_rdata,
    input  if_rdata, if_done, d_rdata, d_done, mem_valid, mem_we, mem_addr, mem_wdata, stall, err
  );
endinterface

// File: rtl/cpu5_memarb.sv
// rtl/cpu5_memarb.sv - shares one single-ported memory between cpu5 fetch and load/store
// One transaction outstanding; data port has priority; a watchdog aborts hung accesses.
module cpu5_memarb #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         reset,
  cpu5_memarb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [CW-1:0] WDOG_MAX = CW'(TIMEOUT_CYCLES);

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            mem_valid_q, mem_valid_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            if_done_q, if_done_d;
  logic            d_done_q, d_done_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            err_q, err_d;
  logic [CW-1:0]   wdog_q, wdog_d;
  logic [CW-1:0]   wdog_inc;
  logic            wdog_hit;
  logic            complete;
  logic            abort;

  // owner_q = 1 means the load/store port owns the current transaction
  always_comb begin
    wdog_inc    = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + CW'(1);
    wdog_hit    = (wdog_inc == WDOG_MAX);
    complete    = 1'b0;
    abort       = 1'b0;
    state_d     = state_q;
    owner_d     = owner_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    wdog_d      = wdog_q;

    case (state_q)
      IDLE: begin
        if (bus.d_req) begin
          owner_d     = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_valid_d = 1'b1;
          wdog_d      = '0;
          state_d     = REQ;
        end else if (bus.if_req) begin
          owner_d     = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_valid_d = 1'b1;
          wdog_d      = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        wdog_d = wdog_inc;
        if (mem_valid_q && bus.mem_ready) begin
          mem_valid_d = 1'b0;
          if (mem_we_q) complete = 1'b1;
          else          state_d  = RESP;
        end else if (wdog_hit) begin
          abort = 1'b1;
        end
      end
      RESP: begin
        wdog_d = wdog_inc;
        if (bus.mem_rvalid) begin
          complete = 1'b1;
          if (owner_q) d_rdata_d  = bus.mem_rdata;
          else         if_rdata_d = bus.mem_rdata;
        end else if (wdog_hit) begin
          abort = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An abort still issues the done pulse so the core can never deadlock
    if (complete || abort) begin
      state_d   = DONE;
      d_done_d  = owner_q;
      if_done_d = ~owner_q;
    end
    if (abort) begin
      mem_valid_d = 1'b0;
      err_d       = 1'b1;
      if (owner_q) d_rdata_d  = '0;
      else         if_rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
  assign bus.stall     = (bus.if_req & ~if_done_q) | (bus.d_req & ~d_done_q);

endmodule

// File: doc/cpu5_memarb.md
Name: cpu5_memarb

Overview:
- Shares one single-ported memory between the instruction-fetch port and the load/store port of the cpu5 datapath.
- Sequences each access as a request → accept → response transaction, with at most one transaction outstanding.
- Drives a stall signal that freezes the PC register and the register-file write while either access is pending.
- Runs a watchdog that aborts hung transactions and flags the error.

Parameters:
- XLEN, 32, address/data width (matches CPU5_XLEN).
- TIMEOUT_CYCLES, 64, max cycles spent in REQ+RESP before abort; must be ≥ 2.
- CW, $clog2(TIMEOUT_CYCLES+1), watchdog counter width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  input  1  fetch request; held with if_addr stable until if_done.
- if_addr  input  XLEN  fetch address (the pc).
- if_rdata  output  XLEN  fetched instruction; valid while if_done=1.
- if_done  output  1  one-cycle completion pulse for fetch.
- d_req  input  1  load/store request; held with d_we/d_addr/d_wdata stable until d_done.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  XLEN  data address (aluout).
- d_wdata  input  XLEN  store data (rs2).
- d_rdata  output  XLEN  load data; valid while d_done=1.
- d_done  output  1  one-cycle completion pulse for load/store.
- mem_valid  output  1  request valid to memory.
- mem_we  output  1  write enable to memory.
- mem_addr  output  XLEN  memory address.
- mem_wdata  output  XLEN  memory write data.
- mem_ready  input  1  memory accepts the request when mem_valid & mem_ready.
- mem_rvalid  input  1  read data valid; ≥1 cycle after a read is accepted.
- mem_rdata  input  XLEN  read data.
- stall  output  1  combinational: (if_req & ~if_done) | (d_req & ~d_done).
- err  output  1  sticky timeout flag; cleared only by reset.

Behaviour:

Reset:
- reset=0 asynchronously forces state IDLE.
- All registered outputs go to 0: mem_valid, mem_we, mem_addr, mem_wdata, if_done, d_done, if_rdata, d_rdata, err.
- Watchdog counter clears to 0.
- Reset mid-transaction drops the transaction silently; no done pulse is produced.

FSM states: IDLE, REQ, RESP, DONE.

IDLE:
- Samples the request inputs.
- If d_req=1, grants data; d_req has fixed priority over if_req because the data access belongs to the instruction already fetched.
- Else if if_req=1, grants fetch.
- On a grant: latch owner, we, address and wdata into the mem_* registers, set mem_valid=1, go to REQ.
- No request: stay in IDLE.

REQ:
- mem_valid=1; mem_* held stable until accepted.
- On mem_valid & mem_ready: clear mem_valid.
- Write accepted: go to DONE.
- Read accepted: go to RESP.
- mem_rvalid is ignored in REQ.

RESP:
- Waits for mem_rvalid=1, then latches mem_rdata into the owner's rdata register and goes to DONE.
- mem_rvalid arriving in any other state is ignored.

DONE:
- Exactly one cycle; the owner's done=1.
- Next state is always IDLE.
- Request inputs are not sampled in DONE; the requester deasserts or changes req at the edge ending the done cycle.
- Result: back-to-back requests cost one IDLE cycle between transactions.

Latency (mem_ready=1, mem_rvalid exactly one cycle after acceptance; req seen in IDLE at cycle 0):
- Read: mem_valid at cycle 1, done at cycle 3.
- Write: done at cycle 2.

Data outputs:
- if_rdata/d_rdata hold their last value; they are not cleared after done.
- For stores, d_rdata is unchanged.

Watchdog:
- Counter clears on entry to REQ and increments each cycle in REQ or RESP.
- When it equals TIMEOUT_CYCLES: force mem_valid=0, load owner's rdata with 0, set err=1, go to DONE (done pulse still issued so the core never deadlocks).
- Counter saturates at TIMEOUT_CYCLES; no wrap.

Simultaneous events:
- Both requests in IDLE: data wins; fetch remains pending and is served on the next IDLE.
- Timeout and acceptance/rvalid in the same cycle: the completion wins and err is not set.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0010, mem_ready=1, mem_rdata=0x0050_0093 one cycle after accept → if_done at cycle 3, if_rdata=0x0050_0093, stall=1 during cycles 0–2, err=0.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF → mem_valid/mem_we=1 with those values at cycle 1; d_done at cycle 2; d_rdata unchanged.
- Contention: if_req and d_req (load 0x104) both rise at cycle 0 → data granted first (d_done at 3), IDLE at 4, fetch mem_valid at 5, if_done at 7.
- Backpressure: mem_ready=0 for 5 cycles, then 1 → mem_* stable for all 6 REQ cycles and exactly one acceptance; mem_rvalid asserted while still in REQ is ignored.
- Timeout with TIMEOUT_CYCLES=8 and mem_ready stuck at 0 → done pulse 8 cycles after REQ entry, rdata=0, err=1 and still 1 after later successful transactions.
- Reset asserted (reset=0) during RESP → all outputs 0 immediately and no done pulse; after release, a new fetch completes normally.
